// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: branch condition codes and the branch-resolve
// pipeline entry layout.
package rv32i_types;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } branch_funct3_t;

   // funct3 codes with no branch meaning; flagged rather than evaluated
   localparam logic [2:0] F3_ILL_A = 3'b010;
   localparam logic [2:0] F3_ILL_B = 3'b011;

   localparam int BRU_DEFAULT_WIDTH = 32;

   typedef struct packed {
      logic                         taken;
      logic                         mispredict;
      logic                         illegal;
      logic [BRU_DEFAULT_WIDTH-1:0] redirect;
   } bru_entry_t;

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational branch condition evaluator: funct3 plus operands to taken and
// an illegal-code flag.
module bru_cond_eval
   import rv32i_types::*;
#(
   parameter int WIDTH = 32
) (
   input  branch_funct3_t   cmpop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             taken,
   output logic             illegal
);

   logic [2:0] op;
   assign op = cmpop;

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (op)
         F3_BEQ:             taken = (a == b);
         F3_BNE:             taken = (a != b);
         F3_BLT:             taken = ($signed(a) < $signed(b));
         F3_BGE:             taken = ($signed(a) >= $signed(b));
         F3_BLTU:            taken = (a < b);
         F3_BGEU:            taken = (a >= b);
         F3_ILL_A, F3_ILL_B: illegal = 1'b1;
         default:            illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution: evaluates the condition, checks the prediction,
// produces the redirect PC through an elastic 1- or 2-entry pipeline.
module branch_resolve_unit
   import rv32i_types::*;
#(
   parameter int WIDTH       = 32,
   parameter int STAGES      = 1,
   parameter int INSTR_BYTES = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  branch_funct3_t       cmpop,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [WIDTH-1:0]     pc,
   input  logic [WIDTH-1:0]     target,
   input  logic                 pred_taken,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_taken,
   output logic                 out_mispredict,
   output logic [WIDTH-1:0]     out_redirect_pc,
   output logic                 out_illegal,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);

   // Same layout as bru_entry_t, but sized by WIDTH
   typedef struct packed {
      logic             taken;
      logic             mispredict;
      logic             illegal;
      logic [WIDTH-1:0] redirect;
   } entry_t;

   logic   ev_taken;
   logic   ev_illegal;
   entry_t ev_entry;

   bru_cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
      .cmpop   (cmpop),
      .a       (a),
      .b       (b),
      .taken   (ev_taken),
      .illegal (ev_illegal)
   );

   always_comb begin
      ev_entry.taken      = ev_taken;
      ev_entry.mispredict = ev_taken ^ pred_taken;
      ev_entry.illegal    = ev_illegal;
      ev_entry.redirect   = ev_taken ? target : pc + WIDTH'(INSTR_BYTES);
   end

   logic   s1_valid;
   entry_t s1_data;
   logic   s1_adv;
   logic   last_valid;
   entry_t last_data;
   logic   last_adv;
   logic   accept;

   assign last_adv = last_valid && out_ready;
   assign in_ready = rst_n && !flush && (!s1_valid || s1_adv);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         if (flush)       s1_valid <= 1'b0;
         else if (accept) s1_valid <= 1'b1;
         else if (s1_adv) s1_valid <= 1'b0;
         if (accept) s1_data <= ev_entry;
      end
   end

   if (STAGES == 2) begin : g_two_stage
      logic   s2_valid;
      entry_t s2_data;

      // Stage 1 moves on when stage 2 is empty or draining this cycle
      assign s1_adv = s1_valid && (!s2_valid || last_adv);

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
         end else begin
            if (flush)         s2_valid <= 1'b0;
            else if (s1_adv)   s2_valid <= 1'b1;
            else if (last_adv) s2_valid <= 1'b0;
            if (s1_adv) s2_data <= s1_data;
         end
      end

      assign last_valid = s2_valid;
      assign last_data  = s2_data;
   end else begin : g_one_stage
      if (STAGES != 1) begin : g_bad_stages
         $error("branch_resolve_unit: STAGES must be 1 or 2");
      end
      assign s1_adv     = last_adv;
      assign last_valid = s1_valid;
      assign last_data  = s1_data;
   end

   assign out_valid       = last_valid;
   assign out_taken       = last_data.taken;
   assign out_mispredict  = last_data.mispredict;
   assign out_illegal     = last_data.illegal;
   assign out_redirect_pc = last_data.redirect;

   // Illegal entries report a mispredict but are excluded from its statistic
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (last_adv) begin
         if (branch_count != '1)
            branch_count <= branch_count + CNT_WIDTH'(1);
         if (last_data.mispredict && !last_data.illegal && mispredict_count != '1)
            mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: three instances (1 stage, 2 stages,
// 2-bit counters) checked against a scoreboard fed from a reference model.
module tb_branch_resolve_unit;
   import rv32i_types::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n, flush, out_ready, pred_taken, in_valid;
   branch_funct3_t cmpop;
   logic [31:0]    a, b, pc, target;
   int             sel;
   logic [2:0]     iv;

   assign iv = in_valid ? (3'b001 << sel) : 3'b000;

   logic        ir0, ov0, ot0, om0, oi0;
   logic [31:0] rp0;
   logic [15:0] bc0, mc0;
   logic        ir1, ov1, ot1, om1, oi1;
   logic [31:0] rp1;
   logic [15:0] bc1, mc1;
   logic        ir2, ov2, ot2, om2, oi2;
   logic [31:0] rp2;
   logic [1:0]  bc2, mc2;

   branch_resolve_unit #(.WIDTH(32), .STAGES(1), .INSTR_BYTES(4), .CNT_WIDTH(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .cmpop(cmpop),
      .a(a), .b(b), .pc(pc), .target(target), .pred_taken(pred_taken), .flush(flush),
      .out_valid(ov0), .out_ready(out_ready), .out_taken(ot0), .out_mispredict(om0),
      .out_redirect_pc(rp0), .out_illegal(oi0), .branch_count(bc0), .mispredict_count(mc0));

   branch_resolve_unit #(.WIDTH(32), .STAGES(2), .INSTR_BYTES(4), .CNT_WIDTH(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .cmpop(cmpop),
      .a(a), .b(b), .pc(pc), .target(target), .pred_taken(pred_taken), .flush(flush),
      .out_valid(ov1), .out_ready(out_ready), .out_taken(ot1), .out_mispredict(om1),
      .out_redirect_pc(rp1), .out_illegal(oi1), .branch_count(bc1), .mispredict_count(mc1));

   branch_resolve_unit #(.WIDTH(32), .STAGES(1), .INSTR_BYTES(4), .CNT_WIDTH(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .cmpop(cmpop),
      .a(a), .b(b), .pc(pc), .target(target), .pred_taken(pred_taken), .flush(flush),
      .out_valid(ov2), .out_ready(out_ready), .out_taken(ot2), .out_mispredict(om2),
      .out_redirect_pc(rp2), .out_illegal(oi2), .branch_count(bc2), .mispredict_count(mc2));

   logic        cur_in_ready, cur_out_valid, cur_taken, cur_mis, cur_ill;
   logic [31:0] cur_rd;
   logic [15:0] cur_bc, cur_mc;

   always_comb begin
      cur_in_ready  = ir0;
      cur_out_valid = ov0;
      cur_taken     = ot0;
      cur_mis       = om0;
      cur_ill       = oi0;
      cur_rd        = rp0;
      cur_bc        = bc0;
      cur_mc        = mc0;
      case (sel)
         1: begin
            cur_in_ready = ir1; cur_out_valid = ov1; cur_taken = ot1; cur_mis = om1;
            cur_ill = oi1; cur_rd = rp1; cur_bc = bc1; cur_mc = mc1;
         end
         2: begin
            cur_in_ready = ir2; cur_out_valid = ov2; cur_taken = ot2; cur_mis = om2;
            cur_ill = oi2; cur_rd = rp2; cur_bc = {14'd0, bc2}; cur_mc = {14'd0, mc2};
         end
         default: ;
      endcase
   end

   typedef struct {
      logic        taken;
      logic        mis;
      logic        ill;
      logic [31:0] rd;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_bc[3];
   int   exp_mc[3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb,
                                  input logic [31:0] rpc, input logic [31:0] rtg, input logic pr);
      exp_t e;
      int   sa, sb;
      sa    = ra;
      sb    = rb;
      e.ill = 1'b0;
      case (op)
         3'b000:  e.taken = (ra == rb);
         3'b001:  e.taken = (ra != rb);
         3'b100:  e.taken = (sa < sb);
         3'b101:  e.taken = !(sa < sb);
         3'b110:  e.taken = (ra < rb);
         3'b111:  e.taken = !(ra < rb);
         default: begin e.taken = 1'b0; e.ill = 1'b1; end
      endcase
      e.mis = (e.taken != pr);
      e.rd  = e.taken ? rtg : rpc + 32'd4;
      return e;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [31:0] rpc, input logic [31:0] rtg, input logic pr);
      cmpop      = branch_funct3_t'(op);
      a          = ra;
      b          = rb;
      pc         = rpc;
      target     = rtg;
      pred_taken = pr;
      in_valid   = 1'b1;
   endtask

   // One clock: score the output handshake and capture acceptance at the
   // falling edge, then return 1 time unit after the rising edge.
   task automatic step(output bit acc);
      exp_t e;
      int   cap;
      cap = (sel == 2) ? 3 : 65535;
      @(negedge clk);
      if (cur_out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("out_taken", {31'd0, cur_taken}, {31'd0, e.taken});
            chk("out_mispredict", {31'd0, cur_mis}, {31'd0, e.mis});
            chk("out_illegal", {31'd0, cur_ill}, {31'd0, e.ill});
            chk("out_redirect_pc", cur_rd, e.rd);
            if (exp_bc[sel] < cap) exp_bc[sel]++;
            if (e.mis && !e.ill && exp_mc[sel] < cap) exp_mc[sel]++;
         end
      end
      acc = in_valid && cur_in_ready;
      if (acc) q.push_back(model(cmpop, a, b, pc, target, pred_taken));
      if (flush) q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_branch_count"}, {16'd0, cur_bc}, exp_bc[sel]);
      chk({tag, "_mispredict_count"}, {16'd0, cur_mc}, exp_mc[sel]);
   endtask

   bit          acc;
   int          idx;
   logic [31:0] rd_hold;
   logic [15:0] bc_before;

   initial begin
      for (int i = 0; i < 3; i++) begin exp_bc[i] = 0; exp_mc[i] = 0; end
      sel = 0; rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(3'b000, 32'd1, 32'd1, 32'h100, 32'h200, 1'b0);

      // Reset held two cycles with a request pending
      @(posedge clk); #1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_in_ready", {31'd0, cur_in_ready}, 32'd0);
         chk("rst_out_valid", {31'd0, cur_out_valid}, 32'd0);
         chk("rst_counts", {cur_bc, cur_mc}, 32'd0);
         @(posedge clk); #1;
      end
      rst_n = 1'b1; in_valid = 1'b0;
      #1 chk("post_rst_in_ready", {31'd0, cur_in_ready}, 32'd1);

      // Signed vs unsigned, one-cycle latency
      drive(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h200, 1'b0);
      step(acc);
      chk("lat1_out_valid", {31'd0, cur_out_valid}, 32'd1);
      drive(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h400, 1'b0);
      step(acc);
      in_valid = 1'b0;
      step(acc);
      chk("drain_out_valid", {31'd0, cur_out_valid}, 32'd0);
      chk("signed_branch_count", {16'd0, cur_bc}, 32'd2);
      chk("signed_mispredict_count", {16'd0, cur_mc}, 32'd1);

      // Illegal code with a taken prediction
      drive(3'b010, 32'd7, 32'd7, 32'h500, 32'h600, 1'b1);
      step(acc);
      in_valid = 1'b0;
      step(acc);
      chk("illegal_branch_count", {16'd0, cur_bc}, 32'd3);
      chk("illegal_mispredict_count", {16'd0, cur_mc}, 32'd1);

      // Back-to-back mix at full throughput, including a PC wrap
      for (int i = 0; i < 8; i++) begin
         logic [2:0] ops [8];
         ops = '{3'b000, 3'b001, 3'b101, 3'b111, 3'b100, 3'b110, 3'b011, 3'b001};
         drive(ops[i], $urandom_range(0, 3) - 32'd1, $urandom_range(0, 3) - 32'd1,
               32'h1000 + 32'(i * 4), 32'h8000 + 32'(i * 8), 1'($urandom_range(0, 1)));
         if (i == 7) begin a = 32'd5; b = 32'd5; pc = 32'hFFFF_FFFC; end
         #1 chk("tput_in_ready", {31'd0, cur_in_ready}, 32'd1);
         step(acc);
      end
      in_valid = 1'b0;
      step(acc);
      chk_counts("mix");

      // Flush with an output handshake in the same cycle
      drive(3'b000, 32'd9, 32'd9, 32'h40, 32'h80, 1'b1);
      step(acc);
      flush = 1'b1;
      drive(3'b001, 32'd1, 32'd2, 32'h44, 32'h88, 1'b0);
      #1 chk("flush_in_ready", {31'd0, cur_in_ready}, 32'd0);
      step(acc);
      flush = 1'b0; in_valid = 1'b0;
      #1 chk("flush_out_valid", {31'd0, cur_out_valid}, 32'd0);
      chk_counts("flush_hs");

      // Two-stage instance: two-cycle latency
      sel = 1;
      drive(3'b001, 32'd1, 32'd2, 32'h700, 32'h900, 1'b1);
      step(acc);
      in_valid = 1'b0;
      chk("lat2_early", {31'd0, cur_out_valid}, 32'd0);
      step(acc);
      chk("lat2_out_valid", {31'd0, cur_out_valid}, 32'd1);
      step(acc);

      // Backpressure: five beq requests, consumer stalled for four cycles
      idx = 0;
      for (int c = 0; c < 30 && (idx < 5 || q.size() != 0); c++) begin
         out_ready = (c >= 4);
         if (idx < 5)
            drive(3'b000, 32'(idx), 32'(idx + (idx % 2)), 32'h2000 + 32'(idx * 16),
                  32'h3000 + 32'(idx * 16), 1'b0);
         else
            in_valid = 1'b0;
         step(acc);
         if (acc) idx++;
         if (c == 1) rd_hold = cur_rd;
         if (c == 2 || c == 3) begin
            chk("stall_in_ready", {31'd0, cur_in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, cur_out_valid}, 32'd1);
            chk("stall_hold", cur_rd, rd_hold);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_all_accepted", 32'(idx), 32'd5);
      chk("bp_drained", 32'(q.size()), 32'd0);
      chk("bp_branch_count", {16'd0, cur_bc}, 32'd6);

      // Flush with two entries in flight and a pending request
      out_ready = 1'b0;
      drive(3'b000, 32'd3, 32'd3, 32'h4000, 32'h5000, 1'b0);
      step(acc);
      drive(3'b000, 32'd4, 32'd4, 32'h4010, 32'h5010, 1'b0);
      step(acc);
      bc_before = cur_bc;
      flush = 1'b1;
      drive(3'b001, 32'd0, 32'd1, 32'h4020, 32'h5020, 1'b0);
      #1 chk("flush2_in_ready", {31'd0, cur_in_ready}, 32'd0);
      step(acc);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1 chk("flush2_out_valid", {31'd0, cur_out_valid}, 32'd0);
      step(acc);
      chk("flush2_out_valid_later", {31'd0, cur_out_valid}, 32'd0);
      chk("flush2_branch_count", {16'd0, cur_bc}, {16'd0, bc_before});
      chk_counts("flush2");

      // Saturation on 2-bit counters
      sel = 2;
      for (int i = 0; i < 5; i++) begin
         drive(3'b000, 32'(i), 32'(i), 32'h10 * 32'(i), 32'h20, 1'b0);
         step(acc);
      end
      in_valid = 1'b0;
      step(acc);
      chk("sat_branch_count", {16'd0, cur_bc}, 32'd3);
      chk("sat_mispredict_count", {16'd0, cur_mc}, 32'd3);
      chk_counts("sat");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
